level_round_judge: RTL and testbench
====================================

// Module: level_round_judge
// PURPOSE
//   Runs one gold-miner level: loads the level goal, counts the level timer down in
//   seconds, accumulates gold value collected, and judges pass/fail at timer expiry
//   or when the field is cleared. Sits directly upstream of the level controller:
//   cycle_level drives its cycleLevel input; level_idx comes back from it.
// PARAMETERS
//   CLK_HZ         50_000_000  clk cycles per timer second (prescaler terminal count + 1)
//   LEVEL_SECONDS  60          seconds loaded at level start (1..127)
//   GOAL_BASE      650         goal for level_idx 0
//   GOAL_STEP      400         goal increment per level; goal = GOAL_BASE + GOAL_STEP*level_idx
// PORTS
//   clk            in   1   system clock
//   resetN         in   1   asynchronous, active-low reset
//   start          in   1   one-cycle pulse: begin level (honoured only in IDLE)
//   level_idx      in   2   current level number from level controller
//   score_valid    in   1   one-cycle pulse: gold item reeled in
//   score_value    in   8   value of that item
//   all_collected  in   1   level: no gold left on field
//   pause          in   1   freeze timer (only with LRJ_PAUSE_EN)
//   running        out  1   1 while state == RUNNING
//   seconds_left   out  7   remaining seconds
//   level_score    out  12  gold value collected this level, saturating
//   goal           out  12  goal latched at start
//   cycle_level    out  1   one-cycle pulse: level passed
//   game_over      out  1   sticky: level failed
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; prescaler 0. Reset mid-level aborts silently.
//   FSM: IDLE -start-> RUNNING -(expiry | all_collected)-> JUDGE -> PASSED | FAILED.
//     PASSED -> IDLE after 1 cycle; FAILED is terminal until resetN.
//   start in IDLE: next edge loads seconds_left=LEVEL_SECONDS, level_score=0,
//     goal=GOAL_BASE+GOAL_STEP*level_idx (12-bit, saturate 4095), prescaler=0.
//     start in any other state ignored.
//   Prescaler: counts 0..CLK_HZ-1 in RUNNING only; tick at CLK_HZ-1, then wraps to 0.
//   On tick: seconds_left decrements; tick that makes it 0 = expiry; never goes below 0.
//   score_valid accepted in RUNNING only (including the expiry cycle);
//     level_score = min(level_score + score_value, 4095). Ignored elsewhere.
//   all_collected sampled in RUNNING: next state JUDGE (the score_valid of that cycle
//     still counts). Expiry and all_collected together -> single JUDGE.
//   JUDGE (1 cycle): level_score >= goal -> PASSED else FAILED.
//   cycle_level = 1 exactly during the PASSED cycle (registered, 1 cycle wide).
//   game_over = 1 from entry to FAILED until resetN.
//   Latency: expiry edge -> JUDGE next cycle -> cycle_level/game_over the cycle after.
//   running deasserts the cycle JUDGE is entered; seconds_left/level_score hold
//     their final values until the next start.
// CONFIGURATION
//   LRJ_PAUSE_EN defined: pause=1 in RUNNING holds prescaler and seconds_left;
//     score_valid and all_collected still honoured; state stays RUNNING.
//   Not defined: pause port present but ignored; timer never freezes.
// TESTING (CLK_HZ=4, LEVEL_SECONDS=3, GOAL_BASE=10, GOAL_STEP=5)
//   1 Reset, start, level_idx=0, score 6+5 before expiry -> goal=10, seconds 3->0
//     over 12 cycles, JUDGE, cycle_level pulse 1 cycle, back to IDLE, running=0.
//   2 level_idx=2 (goal 20), score 8 only -> after expiry game_over=1 and stays;
//     further start pulses ignored until resetN.
//   3 all_collected at second 2 with score 12, level 0 -> judged immediately,
//     cycle_level pulse, seconds_left holds 2.
//   4 Score 200 x 21 pulses -> level_score saturates at 4095; score_valid in IDLE
//     leaves level_score unchanged.
//   5 score_valid=9 in the expiry cycle, prior score 2, level 0 -> 11 >= 10, pass.
//   6 LRJ_PAUSE_EN: pause held 10 cycles mid-level -> seconds_left frozen, expiry
//     10 cycles later; without macro expiry time unchanged. Also resetN low in
//     RUNNING -> all outputs 0, no cycle_level.

Source files
------------

// File: rtl/level_round_judge.sv
// level_round_judge: runs one gold-miner level.
// Loads the level goal on start, counts the level timer down once per CLK_HZ
// clocks, accumulates collected gold value (saturating at 4095) and judges
// pass/fail when the timer expires or the field is cleared.
// Optional feature: define LRJ_PAUSE_EN to let the pause input freeze the timer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last level's values
// RUNNING | timer counting, score accumulating
// JUDGE   | one cycle: compare level_score against goal
// PASSED  | one cycle: cycle_level pulse, then back to IDLE
// FAILED  | terminal: game_over held until resetN

module level_round_judge #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int LEVEL_SECONDS = 60,
    parameter int GOAL_BASE     = 650,
    parameter int GOAL_STEP     = 400
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [1:0]  level_idx,
    input  logic        score_valid,
    input  logic [7:0]  score_value,
    input  logic        all_collected,
    input  logic        pause,
    output logic        running,
    output logic [6:0]  seconds_left,
    output logic [11:0] level_score,
    output logic [11:0] goal,
    output logic        cycle_level,
    output logic        game_over
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_JUDGE,
        S_PASSED,
        S_FAILED
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] prescaler;
    logic          freeze;
    logic          tick;
    logic          expiry;
    logic [31:0]   goal_raw;
    logic [11:0]   goal_load;
    logic [12:0]   score_sum;
    logic [11:0]   score_next;

`ifdef LRJ_PAUSE_EN
    assign freeze = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign freeze       = 1'b0;
`endif

    // Timer tick at prescaler terminal count; expiry is the tick reaching zero.
    assign tick   = (state == S_RUNNING) && !freeze && (prescaler == PRE_TC);
    assign expiry = tick && (seconds_left == 7'd1);

    // Goal for the requested level, clamped to the 12-bit output range.
    always_comb begin
        goal_raw  = 32'(GOAL_BASE) + 32'(GOAL_STEP) * {30'd0, level_idx};
        goal_load = (goal_raw > 32'd4095) ? 12'hFFF : goal_raw[11:0];
    end

    // Saturating score accumulation.
    always_comb begin
        score_sum  = {1'b0, level_score} + {5'd0, score_value};
        score_next = score_sum[12] ? 12'hFFF : score_sum[11:0];
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        running     = 1'b0;
        cycle_level = 1'b0;
        game_over   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUNNING;
            end
            S_RUNNING: begin
                running = 1'b1;
                if (expiry || all_collected) state_nxt = S_JUDGE;
            end
            S_JUDGE: begin
                state_nxt = (level_score >= goal) ? S_PASSED : S_FAILED;
            end
            S_PASSED: begin
                cycle_level = 1'b1;
                state_nxt   = S_IDLE;
            end
            S_FAILED: begin
                game_over = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Level datapath: load on start, count and accumulate while running.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prescaler    <= '0;
            seconds_left <= '0;
            level_score  <= '0;
            goal         <= '0;
        end else if (state == S_IDLE && start) begin
            prescaler    <= '0;
            seconds_left <= 7'(LEVEL_SECONDS);
            level_score  <= '0;
            goal         <= goal_load;
        end else if (state == S_RUNNING) begin
            if (!freeze) prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick && seconds_left != 7'd0) seconds_left <= seconds_left - 7'd1;
            if (score_valid) level_score <= score_next;
        end
    end

endmodule

// File: tb/tb_level_round_judge.sv
// Randomized bench for level_round_judge with a per-level reference model and
// a scoreboard of expected level outcomes consumed by an independent monitor.
module tb_level_round_judge;

    localparam int CLK_HZ = 4;
    localparam int LSEC   = 6;
    localparam int GB     = 10;
    localparam int GS     = 5;
    localparam int ACTIVE = CLK_HZ * LSEC;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [1:0]  level_idx;
    logic        score_valid;
    logic [7:0]  score_value;
    logic        all_collected;
    logic        pause;
    logic        running;
    logic [6:0]  seconds_left;
    logic [11:0] level_score;
    logic [11:0] goal;
    logic        cycle_level;
    logic        game_over;

    level_round_judge #(
        .CLK_HZ(CLK_HZ), .LEVEL_SECONDS(LSEC), .GOAL_BASE(GB), .GOAL_STEP(GS)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start), .level_idx(level_idx),
        .score_valid(score_valid), .score_value(score_value),
        .all_collected(all_collected), .pause(pause), .running(running),
        .seconds_left(seconds_left), .level_score(level_score), .goal(goal),
        .cycle_level(cycle_level), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit pass;
        int secs;
        int score;
        int goal;
        int at_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pass pulse or game_over rise must match the oldest expected outcome.
    logic go_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            go_prev = 1'b0;
        end else begin
            if (cycle_level || (game_over && !go_prev)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=cycle %0d required=no event", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("cycle_level", 32'(cycle_level), 32'(e.pass));
                    chk("game_over", 32'(game_over), 32'(!e.pass));
                    chk("final_seconds", 32'(seconds_left), 32'(e.secs));
                    chk("final_score", 32'(level_score), 32'(e.score));
                    chk("goal", 32'(goal), 32'(e.goal));
                    chk("event_cycle", 32'(cyc), 32'(e.at_cyc));
                    chk("running_at_event", 32'(running), 32'd0);
                end
            end
            go_prev = game_over;
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        resetN = 1'b0;
        #2;
        chk("rst_running", 32'(running), 0);
        chk("rst_seconds", 32'(seconds_left), 0);
        chk("rst_score", 32'(level_score), 0);
        chk("rst_goal", 32'(goal), 0);
        chk("rst_cycle_level", 32'(cycle_level), 0);
        chk("rst_game_over", 32'(game_over), 0);
        @(posedge clk); #1;
        resetN = 1'b1;
    endtask

    // One level: random stimulus per running cycle, reference outcome from the level rules.
    task automatic run_level(input int idx, input int p_score, input int vmax,
                             input int vfix, input int p_all, input int p_pause);
        exp_t e;
        int   score, active, k, s, val, final_score;
        bit   sv, ac, pz, done;
        score  = 0;
        active = 0;
        k      = 0;
        done   = 0;
        e.goal = (GB + GS * idx > 4095) ? 4095 : GB + GS * idx;
        @(posedge clk); #1;
        start     = 1'b1;
        level_idx = 2'(idx);
        s         = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && k < 500) begin
            sv  = ($urandom_range(0, 99) < p_score);
            val = (vfix >= 0) ? vfix : $urandom_range(0, vmax);
            ac  = ($urandom_range(0, 99) < p_all);
            pz  = ($urandom_range(0, 99) < p_pause);
            score_valid   = sv;
            score_value   = 8'(val);
            all_collected = ac;
            pause         = pz;
`ifdef LRJ_PAUSE_EN
            if (!pz) active++;
`else
            active++;
`endif
            if (sv) score = (score + val > 4095) ? 4095 : score + val;
            if (active == ACTIVE) begin
                done   = 1;
                e.secs = 0;
            end else if (ac) begin
                done   = 1;
                e.secs = LSEC - active / CLK_HZ;
            end
            if (done) begin
                e.pass   = (score >= e.goal);
                e.score  = score;
                e.at_cyc = s + 3 + k;
                sb.push_back(e);
            end
            k++;
            @(posedge clk); #1;
        end
        score_valid   = 1'b0;
        all_collected = 1'b0;
        pause         = 1'b0;
        final_score   = score;
        repeat (3) @(posedge clk);
        #1;
        chk("running_after_judge", 32'(running), 0);
        if (e.pass) begin
            // Score pulse while idle must not move the held score.
            score_valid = 1'b1;
            score_value = 8'd50;
            @(posedge clk); #1;
            score_valid = 1'b0;
            @(posedge clk); #1;
            chk("idle_score_hold", 32'(level_score), 32'(final_score));
        end else begin
            // Failed is terminal: start pulses are ignored.
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("failed_start_ignored", 32'(running), 0);
            chk("game_over_sticky", 32'(game_over), 1);
            do_reset();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetN        = 1'b0;
        start         = 1'b0;
        level_idx     = 2'd0;
        score_valid   = 1'b0;
        score_value   = 8'd0;
        all_collected = 1'b0;
        pause         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_running", 32'(running), 0);
        chk("reset_seconds", 32'(seconds_left), 0);
        chk("reset_score", 32'(level_score), 0);
        chk("reset_goal", 32'(goal), 0);
        chk("reset_cycle_level", 32'(cycle_level), 0);
        chk("reset_game_over", 32'(game_over), 0);
        resetN = 1'b1;

        // Saturation: 200 on every running cycle.
        run_level(0, 100, 0, 200, 0, 0);
        // Small scores ending by expiry only, then with field clear likely.
        run_level(2, 30, 10, -1, 0, 0);
        run_level(0, 50, 10, -1, 15, 0);

        for (int i = 0; i < 40; i++)
            run_level($urandom_range(0, 3), 25, 15, -1, 3, 20);

        // Reset in the middle of a level aborts without any outcome.
        @(posedge clk); #1;
        start     = 1'b1;
        level_idx = 2'd0;
        @(posedge clk); #1;
        start         = 1'b0;
        score_valid   = 1'b1;
        score_value   = 8'd100;
        repeat (5) @(posedge clk);
        #1;
        score_valid = 1'b0;
        chk("midlevel_running", 32'(running), 1);
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        chk("abort_running", 32'(running), 0);
        chk("abort_game_over", 32'(game_over), 0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
